// File: rtl/kmeans_acc_block_param.sv
// rtl/kmeans_acc_block_param.sv - per-centroid sum/count accumulator for k-means (optional KMEANS_ACC_SAT_EN saturation)
`timescale 1ns/1ps
module kmeans_acc_block_param #(
    parameter int K  = 3,
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int CW = 8,
    parameter int KW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [KW-1:0]   in_centroid,
    input  logic            in_last,
    output logic            busy,
    output logic            done,
    output logic            err,
    input  logic            rd_req,
    input  logic [KW-1:0]   rd_centroid,
    output logic            rd_valid,
    output logic [N*AW-1:0] rd_sum,
    output logic [CW-1:0]   rd_count
);

    typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

    localparam logic [KW:0] K_LIM = (KW+1)'(K);

    state_t state_q, state_d;
    logic   done_d;

    // Stage 1: captured sample waiting to be committed
    logic            s1_valid;
    logic [N*DW-1:0] s1_data;
    logic [KW-1:0]   s1_centroid;

    // Bank: valid bits allow a one-cycle clear without touching the sums
    logic [K-1:0]    vld_q;
    logic [AW-1:0]   sum_q [K][N];
    logic [CW-1:0]   cnt_q [K];

    logic            sel_vld;
    logic [AW-1:0]   sel_sum [N];
    logic [CW-1:0]   sel_cnt;
    logic [AW:0]     sum_wide [N];
    logic [CW:0]     cnt_wide;
    logic [AW-1:0]   sum_next [N];
    logic [CW-1:0]   cnt_next;

    logic [N*AW-1:0] rd_sum_d;
    logic [CW-1:0]   rd_cnt_d;

    logic in_range;
    logic accept;
    logic rd_ok;

    assign in_range = {1'b0, in_centroid} < K_LIM;
    assign accept   = in_valid && (start || state_q == ACC);
    assign rd_ok    = rd_req && state_q == IDLE;
    assign busy     = state_q != IDLE;

    // Next-state logic; start restarts from any state
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = (accept && in_last) ? FLUSH : ACC;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ACC:     if (accept && in_last) state_d = FLUSH;
                FLUSH: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    // Input stage; out-of-range samples never enter it
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept && in_range;
        end
        s1_data     <= in_data;
        s1_centroid <= in_centroid;
    end

    // Sticky error flag, cleared when an iteration starts
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (start) begin
            err <= accept && !in_range;
        end else if (accept && !in_range) begin
            err <= 1'b1;
        end
    end

    // Fetch the current contents of the centroid being committed
    always_comb begin
        sel_vld = 1'b0;
        sel_cnt = '0;
        for (int d = 0; d < N; d++) sel_sum[d] = '0;
        for (int k = 0; k < K; k++) begin
            if (s1_centroid == KW'(k)) begin
                sel_vld = vld_q[k];
                sel_cnt = cnt_q[k];
                for (int d = 0; d < N; d++) sel_sum[d] = sum_q[k][d];
            end
        end
    end

    // Compute committed values; first write to a cleared centroid replaces
    always_comb begin
        cnt_wide = {1'b0, sel_cnt} + (CW+1)'(1);
`ifdef KMEANS_ACC_SAT_EN
        cnt_next = cnt_wide[CW] ? '1 : cnt_wide[CW-1:0];
`else
        cnt_next = cnt_wide[CW-1:0];
`endif
        if (!sel_vld) cnt_next = CW'(1);
        for (int d = 0; d < N; d++) begin
            sum_wide[d] = {1'b0, sel_sum[d]} + (AW+1)'(s1_data[d*DW +: DW]);
`ifdef KMEANS_ACC_SAT_EN
            sum_next[d] = sum_wide[d][AW] ? '1 : sum_wide[d][AW-1:0];
`else
            sum_next[d] = sum_wide[d][AW-1:0];
`endif
            if (!sel_vld) sum_next[d] = AW'(s1_data[d*DW +: DW]);
        end
    end

    // Bank write; start discards the pending stage-1 sample
    always_ff @(posedge clk) begin
        if (rst || start) begin
            vld_q <= '0;
        end else if (s1_valid) begin
            for (int k = 0; k < K; k++) begin
                if (s1_centroid == KW'(k)) begin
                    vld_q[k] <= 1'b1;
                    cnt_q[k] <= cnt_next;
                    for (int d = 0; d < N; d++) sum_q[k][d] <= sum_next[d];
                end
            end
        end
    end

    // Read mux; cleared or out-of-range centroids read as zero
    always_comb begin
        rd_sum_d = '0;
        rd_cnt_d = '0;
        for (int k = 0; k < K; k++) begin
            if (rd_centroid == KW'(k) && vld_q[k]) begin
                rd_cnt_d = cnt_q[k];
                for (int d = 0; d < N; d++) rd_sum_d[d*AW +: AW] = sum_q[k][d];
            end
        end
    end

    // Read port register, served only in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_sum   <= '0;
            rd_count <= '0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_sum   <= rd_sum_d;
                rd_count <= rd_cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_kmeans_acc_block_param.sv
// tb/tb_kmeans_acc_block_param.sv - self-checking bench for kmeans_acc_block_param
`timescale 1ns/1ps
module tb_kmeans_acc_block_param;

    localparam int K = 3, N = 2, DW = 8, AW = 16, CW = 8, KW = 2;
    localparam int MAXS = (1 << AW) - 1;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst, start, in_valid, in_last, rd_req;
    logic [N*DW-1:0] in_data;
    logic [KW-1:0]   in_centroid, rd_centroid;
    logic            busy, done, err, rd_valid;
    logic [N*AW-1:0] rd_sum;
    logic [CW-1:0]   rd_count;

    int n_cmp = 0;
    int n_bad = 0;
    int m_sum [4][N];
    int m_cnt [4];
    bit m_err;
    int lat;

    kmeans_acc_block_param #(.K(K), .N(N), .DW(DW), .AW(AW), .CW(CW), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_centroid(in_centroid), .in_last(in_last), .busy(busy), .done(done), .err(err),
        .rd_req(rd_req), .rd_centroid(rd_centroid), .rd_valid(rd_valid),
        .rd_sum(rd_sum), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0;
            for (int d = 0; d < N; d++) m_sum[c][d] = 0;
        end
        m_err = 0;
    endtask

    task automatic begin_iter();
        start = 1; in_valid = 0; in_last = 0;
        step();
        start = 0;
        model_clear();
    endtask

    // One sample for one cycle; the model applies the arithmetic directly
    task automatic send(input int c, input int d0, input int d1, input bit last);
        int v;
        in_valid = 1; in_centroid = KW'(c); in_data = {DW'(d1), DW'(d0)}; in_last = last;
        step();
        in_valid = 0; in_last = 0;
        if (c < K) begin
            for (int d = 0; d < N; d++) begin
                v = m_sum[c][d] + (d == 0 ? d0 : d1);
`ifdef KMEANS_ACC_SAT_EN
                m_sum[c][d] = (v > MAXS) ? MAXS : v;
`else
                m_sum[c][d] = v % (MAXS + 1);
`endif
            end
`ifdef KMEANS_ACC_SAT_EN
            m_cnt[c] = (m_cnt[c] + 1 > MAXC) ? MAXC : m_cnt[c] + 1;
`else
            m_cnt[c] = (m_cnt[c] + 1) % (MAXC + 1);
`endif
        end else begin
            m_err = 1;
        end
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (done !== 1'b1 && l < 50) begin
            step();
            l++;
        end
    endtask

    task automatic do_read(input int c);
        rd_req = 1; rd_centroid = KW'(c);
        step();
        rd_req = 0;
    endtask

    function automatic logic [N*AW-1:0] exp_sum(input int c);
        logic [N*AW-1:0] r;
        for (int d = 0; d < N; d++) r[d*AW +: AW] = AW'(m_sum[c][d]);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1; start = 0; in_valid = 0; in_last = 0; rd_req = 0;
        in_data = '0; in_centroid = '0; rd_centroid = '0;
        step(); step();
        rst = 0;
        model_clear();
        n_cmp += 6;
        if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        if (err !== 1'b0)      begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        if (rd_sum !== '0)     begin n_bad++; $display("FAIL reset_rd_sum got %h want 0", rd_sum); end
        if (rd_count !== '0)   begin n_bad++; $display("FAIL reset_rd_count got %h want 0", rd_count); end
        do_read(0);
        n_cmp += 2;
        if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL reset_read_valid got %b want 1", rd_valid); end
        if (rd_sum !== '0)     begin n_bad++; $display("FAIL reset_read_sum got %h want 0", rd_sum); end
    endtask

    task automatic test_basic();
        begin_iter();
        send(0, 3, 4, 0);
        send(1, 10, 20, 0);
        send(0, 1, 1, 1);
        n_cmp += 2;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_flush_busy got %b want 1", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL basic_early_done got %b want 0", done); end
        wait_done(lat);
        n_cmp += 2;
        if (lat !== 1)     begin n_bad++; $display("FAIL basic_done_latency got %0d want 1", lat); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy got %b want 0", busy); end
        for (int c = 0; c < 4; c++) begin
            do_read(c);
            n_cmp += 3;
            if (rd_valid !== 1'b1)          begin n_bad++; $display("FAIL basic_rd_valid c%0d got %b want 1", c, rd_valid); end
            if (rd_sum !== exp_sum(c))      begin n_bad++; $display("FAIL basic_rd_sum c%0d got %h want %h", c, rd_sum, exp_sum(c)); end
            if (rd_count !== CW'(m_cnt[c])) begin n_bad++; $display("FAIL basic_rd_count c%0d got %0d want %0d", c, rd_count, m_cnt[c]); end
        end
        step();
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_rd_valid_drop got %b want 0", rd_valid); end
    endtask

    task automatic test_burst(input int c, input int d0, input int d1, input int n, input string name);
        begin_iter();
        for (int i = 0; i < n; i++) send(c, d0, d1, i == n - 1);
        wait_done(lat);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL %s_done_latency got %0d want 1", name, lat); end
        do_read(c);
        n_cmp += 2;
        if (rd_sum !== exp_sum(c))      begin n_bad++; $display("FAIL %s_rd_sum got %h want %h", name, rd_sum, exp_sum(c)); end
        if (rd_count !== CW'(m_cnt[c])) begin n_bad++; $display("FAIL %s_rd_count got %0d want %0d", name, rd_count, m_cnt[c]); end
    endtask

    task automatic test_restart();
        begin_iter();
        for (int i = 0; i < 5; i++) send(0, 9, 9, 0);
        send(3, 1, 1, 0);
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL restart_err_set got %b want 1", err); end
        start = 1;
        model_clear();
        send(0, 7, 7, 1);
        start = 0;
        n_cmp += 2;
        if (err !== 1'b0)  begin n_bad++; $display("FAIL restart_err_clear got %b want 0", err); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy got %b want 1", busy); end
        wait_done(lat);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL restart_done_latency got %0d want 1", lat); end
        for (int c = 0; c < 2; c++) begin
            do_read(c);
            n_cmp += 2;
            if (rd_sum !== exp_sum(c))      begin n_bad++; $display("FAIL restart_rd_sum c%0d got %h want %h", c, rd_sum, exp_sum(c)); end
            if (rd_count !== CW'(m_cnt[c])) begin n_bad++; $display("FAIL restart_rd_count c%0d got %0d want %0d", c, rd_count, m_cnt[c]); end
        end
    endtask

    task automatic test_error_ignore();
        begin_iter();
        send(0, 5, 6, 0);
        send(3, 9, 9, 0);
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL error_err got %b want 1", err); end
        rd_req = 1; rd_centroid = 0;
        step();
        rd_req = 0;
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL error_rd_in_acc got %b want 0", rd_valid); end
        send(1, 2, 3, 1);
        wait_done(lat);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL error_done_latency got %0d want 1", lat); end
        in_valid = 1; in_centroid = 0; in_data = 16'hffff; in_last = 1;
        step(); step();
        in_valid = 0; in_last = 0;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_sample_busy got %b want 0", busy); end
        if (err !== 1'b1)  begin n_bad++; $display("FAIL error_sticky got %b want 1", err); end
        for (int c = 0; c < 4; c++) begin
            do_read(c);
            n_cmp += 3;
            if (rd_valid !== 1'b1)          begin n_bad++; $display("FAIL error_rd_valid c%0d got %b want 1", c, rd_valid); end
            if (rd_sum !== exp_sum(c))      begin n_bad++; $display("FAIL error_rd_sum c%0d got %h want %h", c, rd_sum, exp_sum(c)); end
            if (rd_count !== CW'(m_cnt[c])) begin n_bad++; $display("FAIL error_rd_count c%0d got %0d want %0d", c, rd_count, m_cnt[c]); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        begin_iter();
        send(0, 4, 4, 0);
        send(1, 5, 5, 0);
        send(3, 6, 6, 0);
        rst = 1;
        step();
        rst = 0;
        model_clear();
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (err !== 1'b0)  begin n_bad++; $display("FAIL rstmid_err got %b want 0", err); end
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) seen_done = 1;
            step();
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done_pulse got %b want 0", seen_done); end
        for (int c = 0; c < 2; c++) begin
            do_read(c);
            n_cmp += 2;
            if (rd_sum !== '0)   begin n_bad++; $display("FAIL rstmid_rd_sum c%0d got %h want 0", c, rd_sum); end
            if (rd_count !== '0) begin n_bad++; $display("FAIL rstmid_rd_count c%0d got %0d want 0", c, rd_count); end
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 4; it++) begin
            begin_iter();
            len = $urandom_range(5, 40);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                send($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), i == len - 1);
            end
            wait_done(lat);
            n_cmp += 2;
            if (lat !== 1)   begin n_bad++; $display("FAIL rand%0d_done_latency got %0d want 1", it, lat); end
            if (err !== m_err) begin n_bad++; $display("FAIL rand%0d_err got %b want %b", it, err, m_err); end
            for (int c = 0; c < 4; c++) begin
                do_read(c);
                n_cmp += 3;
                if (rd_valid !== 1'b1)          begin n_bad++; $display("FAIL rand%0d_rd_valid c%0d got %b want 1", it, c, rd_valid); end
                if (rd_sum !== exp_sum(c))      begin n_bad++; $display("FAIL rand%0d_rd_sum c%0d got %h want %h", it, c, rd_sum, exp_sum(c)); end
                if (rd_count !== CW'(m_cnt[c])) begin n_bad++; $display("FAIL rand%0d_rd_count c%0d got %0d want %0d", it, c, rd_count, m_cnt[c]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst(2, 1, 2, 200, "burst");
        test_burst(1, 255, 255, 300, "overflow");
        test_restart();
        test_error_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
